// File: rtl/gpt_pkg.sv
// gpt_pkg
// Shared definitions for the general-purpose timer blocks.
//   - ic_pol_e  : input-capture edge polarity select
//   - GPT_CNT_W : default timer counter / capture register width
//   - GPT_FLT_W : default input filter length / filter counter width
//   - ic_edge_sel() : picks the active edge out of rise/fall per polarity
package gpt_pkg;

    localparam int GPT_CNT_W = 16;
    localparam int GPT_FLT_W = 4;

    typedef enum logic [1:0] {
        IC_RISE = 2'b00,
        IC_FALL = 2'b01,
        IC_BOTH = 2'b10,
        IC_RSVD = 2'b11
    } ic_pol_e;

    // The reserved encoding behaves like rising-edge capture.
    function automatic logic ic_edge_sel(input ic_pol_e pol, input logic rise, input logic fall);
        logic sel;
        case (pol)
            IC_FALL: sel = fall;
            IC_BOTH: sel = rise | fall;
            default: sel = rise;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ic_filter.sv
// ic_filter
// Digital glitch filter for one synchronised timer input. The filtered level
// only follows the input after it has disagreed on `len` consecutive
// sampling ticks (len of 0 or 1 means the first mismatching tick wins).
// Ports:
//   clk_i, rst_i : timer clock, synchronous active-high reset
//   en           : channel enable; when low the level tracks din directly
//   tick         : one-cycle sampling strobe (filter time base)
//   din          : synchronised input level
//   len          : filter length in ticks
//   lvl          : filtered level
module ic_filter
    import gpt_pkg::*;
#(
    parameter int FLT_W = GPT_FLT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en,
    input  logic             tick,
    input  logic             din,
    input  logic [FLT_W-1:0] len,
    output logic             lvl
);

    logic [FLT_W-1:0] fcnt;
    logic [FLT_W:0]   fcnt_inc;

    // One extra bit so the compare against len cannot wrap.
    assign fcnt_inc = {1'b0, fcnt} + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lvl  <= 1'b0;
            fcnt <= '0;
        end else if (!en) begin
            // Track the input while disabled so enabling never shows an edge.
            lvl  <= din;
            fcnt <= '0;
        end else if (tick) begin
            if (din != lvl) begin
                // len is compared live, so a length change applies to the
                // count already accumulated.
                if (fcnt_inc >= {1'b0, len}) begin
                    lvl  <= din;
                    fcnt <= '0;
                end else if (fcnt != {FLT_W{1'b1}}) begin
                    fcnt <= fcnt_inc[FLT_W-1:0];
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

endmodule

// File: rtl/input_capture_channel.sv
// input_capture_channel
// One input-capture channel of the general-purpose timer: two-flop input
// synchroniser, tick-based digital filter, edge detector and capture
// register with sticky capture / overcapture flags.
// Ports:
//   clk_i, rst_i : timer clock, synchronous active-high reset
//   cce_i        : channel enable; 0 suppresses captures
//   tick_i       : filter sampling strobe from the prescaler divider
//   ti_i         : asynchronous timer input pin
//   icf_i        : filter length in ticks (0 and 1 = unfiltered)
//   ccp_i        : edge select (ic_pol_e encoding)
//   cnt_i        : current timer counter value
//   flag_clr_i   : one-cycle pulse clearing both flags
//   ccr_o        : capture register
//   capture_o    : one-cycle pulse in the cycle ccr_o is updated
//   ccif_o       : sticky capture flag
//   ccof_o       : sticky overcapture flag
module input_capture_channel
    import gpt_pkg::*;
#(
    parameter int CNT_W = GPT_CNT_W,
    parameter int FLT_W = GPT_FLT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cce_i,
    input  logic             tick_i,
    input  logic             ti_i,
    input  logic [FLT_W-1:0] icf_i,
    input  logic [1:0]       ccp_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             flag_clr_i,
    output logic [CNT_W-1:0] ccr_o,
    output logic             capture_o,
    output logic             ccif_o,
    output logic             ccof_o
);

    logic s1;
    logic s2;
    logic flt_lvl;
    logic flt_prev;
    logic rise;
    logic fall;
    logic cap_evt;

    ic_filter #(
        .FLT_W (FLT_W)
    ) u_filter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (cce_i),
        .tick  (tick_i),
        .din   (s2),
        .len   (icf_i),
        .lvl   (flt_lvl)
    );

    always_comb begin
        rise    = flt_lvl & ~flt_prev;
        fall    = ~flt_lvl & flt_prev;
        cap_evt = cce_i & ic_edge_sel(ic_pol_e'(ccp_i), rise, fall);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            flt_prev  <= 1'b0;
            ccr_o     <= '0;
            capture_o <= 1'b0;
            ccif_o    <= 1'b0;
            ccof_o    <= 1'b0;
        end else begin
            s1        <= ti_i;
            s2        <= s1;
            // While disabled the filter level loads s2, so the previous
            // level must load the same value to avoid a false edge.
            flt_prev  <= cce_i ? flt_lvl : s2;
            capture_o <= cap_evt;
            if (cap_evt) begin
                ccr_o <= cnt_i;
            end
            // A capture wins over a clear for ccif; a clear wins for ccof.
            ccif_o <= cap_evt | (ccif_o & ~flag_clr_i);
            ccof_o <= (cap_evt & ccif_o & ~flag_clr_i) | (ccof_o & ~flag_clr_i);
        end
    end

endmodule
